// File: rtl/aes_dec_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the AES-128 inverse cipher.
// Used by aes_inv_cipher_core, its bus interface and its S-box leaf.
package aes_dec_pkg;

    localparam int NR        = 10;
    localparam int KEY_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Byte k of the block is s(k%4, k/4) and sits at bits [127-8k -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32 * c -: 32] = inv_mix_column(s[127 - 32 * c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_core_if.sv
// Block-in / block-out / round-key bus of the AES-128 inverse cipher core.
// master = surrounding system (FIFO, key store, formatter); slave = the core.
interface aes_inv_cipher_core_if;
    import aes_dec_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [127:0]         in_data;
    logic [KEY_IDX_W-1:0] rk_idx;
    logic [127:0]         rk_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [127:0]         out_data;
    logic                 busy;

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box; entry k of the table sits at bits [8*(255-k) +: 8].
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // 255-k equals ~k for an 8-bit k, so the bit offset is just {~in_byte, 3'b000}.
    assign out_byte = INV_SBOX[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched by index.
// Optional AES_INV_FLUSH_EN adds a synchronous flush input that returns the core to IDLE.
module aes_inv_cipher_core
    import aes_dec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AES_INV_FLUSH_EN
    input  logic                 flush,
`endif
    aes_inv_cipher_core_if.slave bus
);

    localparam logic [KEY_IDX_W-1:0] NR_IDX = KEY_IDX_W'(NR);

    state_e               state_q, state_d;
    logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
    logic [127:0]         blk_q, blk_d;
    logic [127:0]         out_data_q, out_data_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] added;
    logic [127:0] mixed;

    assign shifted = inv_shift_rows(blk_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .in_byte  (shifted[8 * i +: 8]),
            .out_byte (subbed[8 * i +: 8])
        );
    end

    assign added = subbed ^ bus.rk_data;
    assign mixed = inv_mix_columns(added);

    always_comb begin
        // NOTE: every _d starts from its held value so no branch below can infer a latch.
        state_d    = state_q;
        rnd_d      = rnd_q;
        blk_d      = blk_q;
        out_data_d = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    blk_d   = bus.in_data ^ bus.rk_data;
                    rnd_d   = NR_IDX - KEY_IDX_W'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q != '0) begin
                    blk_d = mixed;
                    rnd_d = rnd_q - KEY_IDX_W'(1);
                end else begin
                    // Final round skips InvMixColumns; the counter parks at NR so rk_idx stays in range.
                    out_data_d = added;
                    rnd_d      = NR_IDX;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rnd_d   = NR_IDX;
            end
        endcase

`ifdef AES_INV_FLUSH_EN
        if (flush) begin
            state_d    = IDLE;
            rnd_d      = NR_IDX;
            out_data_d = '0;
        end
`endif

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= NR_IDX;
            blk_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            blk_q       <= blk_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rk_idx    = rnd_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed bench for aes_inv_cipher_core: FIPS-197 vectors, backpressure, back-to-back, reset abort.
// Round keys come from an independent key-expansion model; flush cases run when AES_INV_FLUSH_EN is defined.
module tb_aes_inv_cipher_core;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic rst_n;
`ifdef AES_INV_FLUSH_EN
    logic flush;
`endif

    aes_inv_cipher_core_if bus ();

    aes_inv_cipher_core dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_INV_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] rk_tab [2][11];
    logic         key_sel;

    assign bus.rk_data = (bus.rk_idx <= 4'd10) ? rk_tab[key_sel][bus.rk_idx] : 128'h0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: GF multiply, forward S-box from the inverse + affine map, key schedule.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input int sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_fwd(t[31:24]), sbox_fwd(t[23:16]), sbox_fwd(t[15:8]), sbox_fwd(t[7:0])}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[sel][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Passive monitor: handshake log, out_valid count, rk_idx range.
    int           cyc = 0;
    int           acc_q [$];
    logic [127:0] out_q [$];
    int           vcount = 0;
    int           bad_idx = 0;

    always @(posedge clk) begin
        cyc++;
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (bus.out_valid) begin
            vcount++;
            if (bus.out_ready) out_q.push_back(bus.out_data);
        end
        if (bus.rk_idx > 4'd10) bad_idx++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit           ok;
        int           v0;
        logic [127:0] held;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        key_sel       = 1'b0;
`ifdef AES_INV_FLUSH_EN
        flush         = 1'b0;
`endif
        expand(0, KEY_C1);
        expand(1, KEY_B);
        check("model_rk10_c1", rk_tab[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_rk10_b",  rk_tab[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset state
        step();
        step();
        check("rst_in_ready",  128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy",      128'(bus.busy), 128'd0);
        check("rst_out_data",  bus.out_data, 128'h0);
        check("rst_rk_idx",    128'(bus.rk_idx), 128'd10);
        rst_n = 1'b1;
        step();

        // C.1 with in_valid held through ROUND/DONE and out_ready low
        bus.in_valid = 1'b1;
        bus.in_data  = CT_C1;
        check("c1_rk_idx_accept", 128'(bus.rk_idx), 128'd10);
        step();
        bus.in_data = 128'hdeadbeef_00000000_cafef00d_12345678;
        check("c1_in_ready_round", 128'(bus.in_ready), 128'd0);
        check("c1_busy_round",     128'(bus.busy), 128'd1);
        for (int r = 9; r >= 0; r--) begin
            check($sformatf("c1_rk_idx_%0d", r), 128'(bus.rk_idx), 128'(r));
            check($sformatf("c1_no_valid_%0d", r), 128'(bus.out_valid), 128'd0);
            step();
        end
        check("c1_out_valid_e10", 128'(bus.out_valid), 128'd1);
        check("c1_out_data",      bus.out_data, PT_C1);

        // Backpressure: 20 cycles with out_ready low
        held = bus.out_data;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check("bp_out_data",  bus.out_data, held);
            check("bp_in_ready",  128'(bus.in_ready), 128'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_rel_in_ready",  128'(bus.in_ready), 128'd1);
        check("bp_rel_out_valid", 128'(bus.out_valid), 128'd0);
        check("bp_rel_busy",      128'(bus.busy), 128'd0);

        // App. B with out_ready already high before DONE
        key_sel      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = CT_B;
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        check("b_no_valid_e9", 128'(bus.out_valid), 128'd0);
        step();
        check("b_out_valid_e10", 128'(bus.out_valid), 128'd1);
        check("b_out_data",      bus.out_data, PT_B);
        step();
        check("b_back_idle", 128'(bus.in_ready), 128'd1);

        // Back-to-back with in_valid held
        acc_q.delete();
        out_q.delete();
        key_sel      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = CT_C1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (acc_q.size() == 1 && bus.out_valid) begin
                key_sel     = 1'b1;
                bus.in_data = CT_B;
            end
            if (acc_q.size() >= 2) bus.in_valid = 1'b0;
            if (out_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_done_in_time", 128'(ok), 128'd1);
        if (acc_q.size() >= 2 && out_q.size() >= 2) begin
            check("b2b_interval", 128'(acc_q[1] - acc_q[0]), 128'd12);
            check("b2b_first",    out_q[0], PT_C1);
            check("b2b_second",   out_q[1], PT_B);
        end else begin
            check("b2b_handshakes", 128'(acc_q.size() + out_q.size()), 128'd4);
        end
        bus.in_valid = 1'b0;
        step();
        step();

        // Reset at E5 aborts the block
        key_sel      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = CT_C1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        v0    = vcount;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        check("abort_in_ready",  128'(bus.in_ready), 128'd1);
        check("abort_busy",      128'(bus.busy), 128'd0);
        check("abort_rk_idx",    128'(bus.rk_idx), 128'd10);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("abort_no_output", 128'(vcount - v0), 128'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = CT_C1;
        step();
        bus.in_valid = 1'b0;
        wait_out(20, ok);
        check("post_abort_timeout", 128'(ok), 128'd1);
        check("post_abort_data",    bus.out_data, PT_C1);
        step();

`ifdef AES_INV_FLUSH_EN
        // Flush at E3 of a block
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = CT_C1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", 128'(bus.out_valid), 128'd0);
        check("flush_in_ready",  128'(bus.in_ready), 128'd1);
        check("flush_busy",      128'(bus.busy), 128'd0);
        check("flush_out_data",  bus.out_data, 128'h0);
        check("flush_rk_idx",    128'(bus.rk_idx), 128'd10);
        v0 = vcount;
        for (int i = 0; i < 12; i++) step();
        check("flush_no_output", 128'(vcount - v0), 128'd0);
        // Flush wins over a simultaneous acceptance
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_acc_in_ready", 128'(bus.in_ready), 128'd1);
        check("flush_acc_busy",     128'(bus.busy), 128'd0);
        step();
        check("flush_acc_still_idle", 128'(bus.busy), 128'd0);
`endif

        check("rk_idx_range", 128'(bad_idx), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
